// File: rtl/alu_sequencer_if.sv
// Issue/writeback bus between fetch, the sequencer and the ALU.
// The slave side is the sequencer; the master side is whoever drives fetch/ALU.
interface alu_sequencer_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [7:0]  alu_op;
  logic [15:0] alu_result;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        busy;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  modport slave (
    input  instr, instr_valid, alu_result, alu_flags, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_op, psr, busy, dbg_data
  );

  modport master (
    output instr, instr_valid, alu_result, alu_flags, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_op, psr, busy, dbg_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// Three-cycle issue/execute/writeback controller for the 16-bit ALU.
// Owns a 16x16 register file and the processor status register.
module alu_sequencer #(
  parameter int NREGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_sequencer_if.slave    bus
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  localparam logic [3:0] C_ADD = 4'b0101;
  localparam logic [3:0] C_SUB = 4'b1001;
  localparam logic [3:0] C_CMP = 4'b1011;
  localparam logic [4:0] M_ARITH = 5'b00101;  // C, F
  localparam logic [4:0] M_CMP   = 5'b11010;  // N, Z, L

  state_t                       state_q, state_d;
  logic [NREGS-1:0][15:0]       rf_q, rf_d;
  logic [15:0]                  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [7:0]                   alu_op_q, alu_op_d;
  logic [3:0]                   rdest_q, rdest_d;
  logic                         we_q, we_d;
  logic [4:0]                   mask_q, mask_d;
  logic [15:0]                  res_q, res_d;
  logic [4:0]                   flags_q, flags_d;
  logic [4:0]                   psr_q, psr_d;

  // Decode: R-type takes the ALU code from the ext field, I-type from op.
  logic [3:0]  op, code;
  logic        r_type;
  assign op     = bus.instr[15:12];
  assign r_type = (op == 4'b0000);
  assign code   = r_type ? bus.instr[7:4] : op;

  always_comb begin
    state_d  = state_q;
    rf_d     = rf_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    rdest_d  = rdest_q;
    we_d     = we_q;
    mask_d   = mask_q;
    res_d    = res_q;
    flags_d  = flags_q;
    psr_d    = psr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          state_d  = S_EXEC;
          alu_op_d = {4'b0000, code};
          alu_a_d  = rf_q[bus.instr[11:8]];
          alu_b_d  = r_type ? rf_q[bus.instr[3:0]]
                            : {{8{bus.instr[7]}}, bus.instr[7:0]};
          rdest_d  = bus.instr[11:8];
          we_d     = (code != C_CMP);
          if (code == C_ADD || code == C_SUB) mask_d = M_ARITH;
          else if (code == C_CMP)             mask_d = M_CMP;
          else                                mask_d = 5'b00000;
        end
      end
      S_EXEC: begin
        res_d   = bus.alu_result;
        flags_d = bus.alu_flags;
        state_d = S_WB;
      end
      S_WB: begin
        if (we_q) rf_d[rdest_q] = res_q;
        psr_d   = (psr_q & ~mask_q) | (flags_q & mask_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rf_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      rdest_q  <= '0;
      we_q     <= 1'b0;
      mask_q   <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      psr_q    <= '0;
    end else begin
      state_q  <= state_d;
      rf_q     <= rf_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      rdest_q  <= rdest_d;
      we_q     <= we_d;
      mask_q   <= mask_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      psr_q    <= psr_d;
    end
  end

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.busy        = (state_q == S_EXEC) || (state_q == S_WB);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.psr         = psr_q;
  assign bus.dbg_data    = rf_q[bus.dbg_addr];
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU on the bus.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  alu_sequencer_if bus();

  alu_sequencer #(.NREGS(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [4:0]  cmp_flags = 5'b00000;
  logic [7:0]  exec_op;
  logic [15:0] exec_b;
  logic [15:0] rd;

  // ALU: ADD/SUB produce real flags, CMP returns the bench-chosen flags.
  always_comb begin
    logic [16:0] s;
    s = '0;
    bus.alu_result = bus.alu_a & bus.alu_b;
    bus.alu_flags  = 5'b00000;
    case (bus.alu_op)
      8'h05: begin
        s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_result = s[15:0];
        bus.alu_flags[0] = s[16];
        bus.alu_flags[2] = (bus.alu_a[15] == bus.alu_b[15]) && (s[15] != bus.alu_a[15]);
        bus.alu_flags[3] = (s[15:0] == 16'h0);
        bus.alu_flags[4] = s[15];
      end
      8'h09: begin
        s = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        bus.alu_result = s[15:0];
        bus.alu_flags[0] = s[16];
        bus.alu_flags[2] = (bus.alu_a[15] != bus.alu_b[15]) && (s[15] != bus.alu_a[15]);
        bus.alu_flags[3] = (s[15:0] == 16'h0);
        bus.alu_flags[4] = s[15];
      end
      8'h0B: begin
        bus.alu_result = bus.alu_a - bus.alu_b;
        bus.alu_flags  = cmp_flags;
      end
      default: ;
    endcase
  end

  task automatic read_reg(input logic [3:0] a, output logic [15:0] d);
    bus.dbg_addr = a;
    #1 d = bus.dbg_data;
  endtask

  // Issue one instruction from idle and run it to completion; snapshot EXEC outputs.
  task automatic issue(input logic [15:0] i);
    @(negedge clk);
    bus.instr = i;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    bus.instr = 16'hDEAD;
    @(negedge clk);
    exec_op = bus.alu_op;
    exec_b  = bus.alu_b;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.instr = 16'h0; bus.instr_valid = 1'b0; bus.dbg_addr = 4'h0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.psr !== 5'b0) $display("FAIL reset_psr got %h want 00", bus.psr); else pass_cnt++;
    total_cnt++; if (bus.instr_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.instr_ready); else pass_cnt++;
    total_cnt++; if (bus.alu_op !== 8'h00) $display("FAIL reset_alu_op got %h want 00", bus.alu_op); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      read_reg(4'(i), rd);
      total_cnt++; if (rd !== 16'h0) $display("FAIL reset_rf%0d got %h want 0000", i, rd); else pass_cnt++;
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addi_add();
    issue(16'h5105);
    total_cnt++; if (exec_op !== 8'h05) $display("FAIL addi_op got %h want 05", exec_op); else pass_cnt++;
    total_cnt++; if (exec_b !== 16'h0005) $display("FAIL addi_b got %h want 0005", exec_b); else pass_cnt++;
    read_reg(4'd1, rd);
    total_cnt++; if (rd !== 16'h0005) $display("FAIL addi_r1 got %h want 0005", rd); else pass_cnt++;
    issue(16'h0151);
    total_cnt++; if (exec_op !== 8'h05) $display("FAIL add_op got %h want 05", exec_op); else pass_cnt++;
    read_reg(4'd1, rd);
    total_cnt++; if (rd !== 16'h000A) $display("FAIL add_r1 got %h want 000a", rd); else pass_cnt++;
  endtask

  task automatic test_sign_carry();
    issue(16'h52FF);
    total_cnt++; if (exec_b !== 16'hFFFF) $display("FAIL sext_b got %h want ffff", exec_b); else pass_cnt++;
    read_reg(4'd2, rd);
    total_cnt++; if (rd !== 16'hFFFF) $display("FAIL sext_r2 got %h want ffff", rd); else pass_cnt++;
    total_cnt++; if (bus.psr !== 5'b00000) $display("FAIL sext_psr got %b want 00000", bus.psr); else pass_cnt++;
    issue(16'h5201);
    read_reg(4'd2, rd);
    total_cnt++; if (rd !== 16'h0000) $display("FAIL carry_r2 got %h want 0000", rd); else pass_cnt++;
    total_cnt++; if (bus.psr !== 5'b00001) $display("FAIL carry_psr got %b want 00001", bus.psr); else pass_cnt++;
  endtask

  task automatic test_compare();
    cmp_flags = 5'b11010;
    issue(16'h01B2);
    total_cnt++; if (exec_op !== 8'h0B) $display("FAIL cmp_op got %h want 0b", exec_op); else pass_cnt++;
    read_reg(4'd1, rd);
    total_cnt++; if (rd !== 16'h000A) $display("FAIL cmp_r1 got %h want 000a", rd); else pass_cnt++;
    total_cnt++; if (bus.psr !== 5'b11011) $display("FAIL cmp_psr got %b want 11011", bus.psr); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [3];
    int idx = 0;
    logic rdy;
    prog[0] = 16'h5401; prog[1] = 16'h5402; prog[2] = 16'h5403;
    bus.instr = prog[0];
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      rdy = bus.instr_ready;
      total_cnt++; if (rdy !== (c % 3 == 0)) $display("FAIL b2b_ready c%0d got %b want %b", c, rdy, (c % 3 == 0)); else pass_cnt++;
      total_cnt++; if (bus.busy !== (c % 3 != 0)) $display("FAIL b2b_busy c%0d got %b want %b", c, bus.busy, (c % 3 != 0)); else pass_cnt++;
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        idx++;
        if (idx < 3) bus.instr = prog[idx];
        else bus.instr_valid = 1'b0;
      end
    end
    bus.instr_valid = 1'b0;
    read_reg(4'd4, rd);
    total_cnt++; if (rd !== 16'h0006) $display("FAIL b2b_r4 got %h want 0006", rd); else pass_cnt++;
    total_cnt++; if (bus.psr !== 5'b11010) $display("FAIL b2b_psr got %b want 11010", bus.psr); else pass_cnt++;
  endtask

  task automatic test_reset_exec();
    @(negedge clk);
    bus.instr = 16'h537F;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL rstx_pre_busy got %b want 1", bus.busy); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.psr !== 5'b0) $display("FAIL rstx_psr got %b want 00000", bus.psr); else pass_cnt++;
    total_cnt++; if (bus.instr_ready !== 1'b1) $display("FAIL rstx_ready got %b want 1", bus.instr_ready); else pass_cnt++;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    read_reg(4'd3, rd);
    total_cnt++; if (rd !== 16'h0000) $display("FAIL rstx_r3 got %h want 0000", rd); else pass_cnt++;
    read_reg(4'd4, rd);
    total_cnt++; if (rd !== 16'h0000) $display("FAIL rstx_r4 got %h want 0000", rd); else pass_cnt++;
    total_cnt++; if (bus.instr_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL rstx_idle got ready=%b busy=%b want ready=1 busy=0", bus.instr_ready, bus.busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_addi_add();
    test_sign_carry();
    test_compare();
    test_back_to_back();
    test_reset_exec();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue/writeback controller that drives the 16-bit ALU and consumes its result and flags. It accepts one 16-bit instruction at a time over a valid/ready handshake, reads operands from an internal 16×16 register file, and presents `Op`/`A`/`B` to the ALU. It then writes the ALU output back to the destination register and merges the ALU flags into a processor status register (PSR). It sits between instruction fetch and the ALU in the CPU datapath.

## Interface
- `NREGS`, 16: register-file depth; fixed at 16 (4-bit register fields).
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `instr`, in, 16: instruction word `{op[15:12], rdest[11:8], ext_or_immhi[7:4], rsrc_or_immlo[3:0]}`.
- `instr_valid`, in, 1: `instr` is valid.
- `instr_ready`, out, 1: block can accept an instruction; high only in IDLE.
- `alu_a`, out, 16: ALU operand A, always `rf[rdest]`.
- `alu_b`, out, 16: ALU operand B, either `rf[rsrc]` or sign-extended imm8.
- `alu_op`, out, 8: ALU op-code.
- `alu_result`, in, 16: ALU output (combinational from `alu_a`/`alu_b`/`alu_op`).
- `alu_flags`, in, 5: ALU flags: [0] C, [1] L, [2] F, [3] Z, [4] N.
- `psr`, out, 5: status register, same bit order as `alu_flags`.
- `busy`, out, 1: high in EXEC or WB.
- `dbg_addr`, in, 4: register-file debug read address.
- `dbg_data`, out, 16: `rf[dbg_addr]`, combinational read.

## Operation
- **Decode, R-type** (`op == 4'b0000`):
  - `alu_op = {4'b0000, instr[7:4]}`
  - `alu_b = rf[instr[3:0]]`
- **Decode, I-type** (`op != 0`):
  - `alu_op = {4'b0000, op}`, so ADDI (op `0101`) issues ALU ADD `8'b00000101`.
  - `alu_b = {{8{instr[7]}}, instr[7:0]}`.
- **Compare class**: code `4'b1011` (`ext` for R-type, `op` for I-type) is CMP/CMPI. It updates the PSR only; no register write.
- **PSR update masks**, applied in WB:
  - Arithmetic class, code `0101` (ADD) or `1001` (SUB): write C (bit 0) and F (bit 2) from `alu_flags`.
  - Compare class: write L (bit 1), Z (bit 3) and N (bit 4).
  - All other codes: PSR unchanged.
  - Bits outside the mask always hold their value.
- **FSM states**:
  - IDLE: `instr_ready = 1`. On `instr_valid & instr_ready`, register the decoded `alu_op`/`alu_a`/`alu_b` plus `rdest`, the write-enable and the PSR mask, then go to EXEC. Otherwise stay in IDLE.
  - EXEC: outputs are stable. At the end of the cycle, capture `alu_result` and `alu_flags` into holding registers, then go to WB.
  - WB: if the write-enable is set, `rf[rdest] <= result`; PSR merges through the mask. Go to IDLE.
- **Held outputs**: `alu_a`/`alu_b`/`alu_op` hold their last issued values in WB and IDLE until the next accept.
- **Hazards**: none. The next operand read occurs only after WB has completed, so same-register back-to-back instructions always see the new value.
- **Width rules**: `alu_result` is taken as 16 bits with no truncation or extension; immediates are sign-extended only.

## Timing
- **Reset** (`rst_n` low, asynchronous) forces:
  - state IDLE, `instr_ready = 1`, `busy = 0`, `psr = 5'b0`
  - `alu_a = alu_b = 16'h0`, `alu_op = 8'h00`
  - all `rf` entries `16'h0`, holding registers cleared
- **Reset mid-operation** (EXEC or WB): aborts the instruction with no register or PSR write. Deassertion is taken synchronously at the next edge.
- **Latency**:
  - Accept at edge E0.
  - ALU inputs valid after E0.
  - Result captured at E1.
  - rf/PSR updated at E2, and `instr_ready` is high after E2.
- **Throughput**: one instruction per 3 cycles. `instr_valid` held high with new data is accepted every third edge.
- **Handshake**: `instr` is sampled only on the accept edge. Changes to `instr` while busy are ignored.
- **`dbg_data` vs writes**: a `dbg_data` read of a register written in WB shows the old value during WB and the new value after E2.

## Test plan
- **Reset**: assert `rst_n = 0` asynchronously mid-cycle → immediately `psr = 0`, `instr_ready = 1`, `alu_op = 0`. Then `dbg_addr` 0..15 → all read `16'h0`.
- **ADDI + ADD**:
  - ADDI R1, 0x05 (`instr 16'h5105`) → after 3 edges `rf[1] = 16'h0005`; during EXEC `alu_op = 8'h05`, `alu_b = 16'h0005`.
  - Then ADD R1, R1 (`16'h0151`) → `rf[1] = 16'h000A`.
- **Sign-extend and carry**:
  - ADDI R2, 0xFF (`16'h52FF`) → `alu_b = 16'hFFFF`, `rf[2] = 16'hFFFF`.
  - ADDI R2, 0x01 → `rf[2] = 16'h0000`, `psr[0] = 1`; `psr[3]` unchanged.
- **Compare**: CMP R1, R2 (`16'h01B2`) with ALU flags `5'b11010` → `rf[1]` unchanged and `psr[4,3,1] = 1,1,1`. C/F bits keep their prior values.
- **Handshake**: hold `instr_valid = 1` with three ADDIs → accepts on edges 0, 3 and 6 only; `busy` high for exactly 2 of every 3 cycles.
- **Reset in EXEC**: `rst_n` pulsed low during EXEC of ADDI R3, 0x7F → `rf[3] = 0`, `psr = 0`, state IDLE.
